bias_relu_avgpool: RTL and testbench

BIAS_RELU_AVGPOOL -- requirements
Module: bias_relu_avgpool

---
 rtl/bra_pkg.sv | 28 ++
 rtl/bra_sat_add.sv | 23 ++
 rtl/bias_relu_avgpool.sv | 139 +++++++++++++
 tb/tb_bias_relu_avgpool.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bra_pkg.sv
// Shared definitions for bias_relu_avgpool: lane geometry, FSM state type,
// saturation limits and the pooling multiply helper.
package bra_pkg;

    localparam int LANES  = 16;
    localparam int ACC_W  = 32;
    localparam int POOL_W = 16;
    localparam int COE_W  = 8;
    localparam int PROD_W = POOL_W + COE_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Signed sample times unsigned coefficient; the exact product always fits
    // in PROD_W signed bits, so it is formed at that width and sign-extended.
    function automatic logic [ACC_W-1:0] pool_mul(input logic signed [POOL_W-1:0] d,
                                                  input logic        [COE_W-1:0]  c);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(d) * PROD_W'($signed({1'b0, c}));
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/bra_sat_add.sv
// One lane of the bias adder: signed ACC_W-bit add clamped to the
// representable range instead of wrapping.
module bra_sat_add
    import bra_pkg::*;
(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] y
);

    logic [ACC_W:0] sum;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            y = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            y = sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/bias_relu_avgpool.sv
// Bias add with saturation, ReLU and average-pool scaling over 16 lanes, plus
// bias-buffer address sequencing. Define BRA_AVG_POOL_EN to build the pool multipliers.
module bias_relu_avgpool #(
    parameter int LANES  = bra_pkg::LANES,
    parameter int ACC_W  = bra_pkg::ACC_W,
    parameter int POOL_W = bra_pkg::POOL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      calculate_enable,
    input  logic [4:0]                part_num,
    input  logic [7:0]                out_piece,
    input  logic [7:0]                addr_start_b,
    input  logic [LANES*ACC_W-1:0]    npe_data,
    input  logic                      npe_data_valid,
    input  logic                      pe_out_en,
    input  logic [LANES*ACC_W-1:0]    bias_data,
    input  logic                      bias_data_valid,
    input  logic                      calculate_end,
    input  logic                      relu_en,
    input  logic [7:0]                avg_coe,
    input  logic [LANES*POOL_W-1:0]   avg_mdata,
    output logic [7:0]                o_b_addr,
    output logic                      o_rd_en,
    output logic [LANES*ACC_W-1:0]    o_bias_result,
    output logic                      o_bias_result_valid,
    output logic [LANES*ACC_W-1:0]    o_relu_data,
    output logic [LANES*ACC_W-1:0]    o_avg_result
);

    import bra_pkg::*;

    state_t                 state;
    logic [4:0]             beat;
    logic [7:0]             piece;
    logic [LANES*ACC_W-1:0] bias_reg;
    logic [LANES*ACC_W-1:0] sum_all;
    logic                   stay_run;

    // calculate_end beats everything, including a simultaneous enable.
    assign stay_run = (state == RUN) && calculate_enable && !calculate_end;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beat     <= '0;
            piece    <= '0;
            o_b_addr <= '0;
            o_rd_en  <= 1'b0;
        end else begin
            o_rd_en <= stay_run && pe_out_en;
            case (state)
                IDLE: begin
                    if (calculate_enable && !calculate_end) begin
                        state    <= RUN;
                        o_b_addr <= addr_start_b;
                        beat     <= '0;
                        piece    <= '0;
                    end
                end
                RUN: begin
                    if (!stay_run) begin
                        state <= IDLE;
                    end else if (npe_data_valid) begin
                        if (beat == part_num) begin
                            beat <= '0;
                            if (piece == out_piece) begin
                                piece    <= '0;
                                o_b_addr <= addr_start_b;
                            end else begin
                                piece    <= piece + 8'd1;
                                o_b_addr <= o_b_addr + 8'd1;
                            end
                        end else begin
                            beat <= beat + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bra_sat_add u_sat (
            .a (npe_data[ACC_W*i +: ACC_W]),
            .b (bias_reg[ACC_W*i +: ACC_W]),
            .y (sum_all[ACC_W*i +: ACC_W])
        );
    end

    // Outside a layer the partial sums pass straight through unbiased.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bias_reg            <= '0;
            o_bias_result       <= '0;
            o_bias_result_valid <= 1'b0;
        end else begin
            if (bias_data_valid) begin
                bias_reg <= bias_data;
            end
            o_bias_result_valid <= npe_data_valid;
            if (!npe_data_valid) begin
                o_bias_result <= '0;
            end else if (state == RUN) begin
                o_bias_result <= sum_all;
            end else begin
                o_bias_result <= npe_data;
            end
        end
    end

    always_comb begin
        o_relu_data = o_bias_result;
        for (int i = 0; i < LANES; i++) begin
            if (relu_en && o_bias_result[ACC_W*i+ACC_W-1]) begin
                o_relu_data[ACC_W*i +: ACC_W] = '0;
            end
        end
    end

`ifdef BRA_AVG_POOL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_avg_result <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                o_avg_result[ACC_W*i +: ACC_W] <= pool_mul(avg_mdata[POOL_W*i +: POOL_W], avg_coe);
            end
        end
    end
`else
    logic unused_avg;
    assign unused_avg   = ^{avg_coe, avg_mdata};
    assign o_avg_result = '0;
`endif

endmodule

// File: tb/tb_bias_relu_avgpool.sv
// Directed self-checking bench for bias_relu_avgpool: bias results are
// predicted into a scoreboard queue and compared when the DUT emits them.
module tb_bias_relu_avgpool;

    localparam int L  = 16;
    localparam int AW = 32;
    localparam int PW = 16;
`ifdef BRA_AVG_POOL_EN
    localparam bit AVG_ON = 1'b1;
`else
    localparam bit AVG_ON = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            calculate_enable;
    logic [4:0]      part_num;
    logic [7:0]      out_piece;
    logic [7:0]      addr_start_b;
    logic [L*AW-1:0] npe_data;
    logic            npe_data_valid;
    logic            pe_out_en;
    logic [L*AW-1:0] bias_data;
    logic            bias_data_valid;
    logic            calculate_end;
    logic            relu_en;
    logic [7:0]      avg_coe;
    logic [L*PW-1:0] avg_mdata;
    logic [7:0]      o_b_addr;
    logic            o_rd_en;
    logic [L*AW-1:0] o_bias_result;
    logic            o_bias_result_valid;
    logic [L*AW-1:0] o_relu_data;
    logic [L*AW-1:0] o_avg_result;

    bias_relu_avgpool dut (
        .clk                 (clk),
        .rst                 (rst),
        .calculate_enable    (calculate_enable),
        .part_num            (part_num),
        .out_piece           (out_piece),
        .addr_start_b        (addr_start_b),
        .npe_data            (npe_data),
        .npe_data_valid      (npe_data_valid),
        .pe_out_en           (pe_out_en),
        .bias_data           (bias_data),
        .bias_data_valid     (bias_data_valid),
        .calculate_end       (calculate_end),
        .relu_en             (relu_en),
        .avg_coe             (avg_coe),
        .avg_mdata           (avg_mdata),
        .o_b_addr            (o_b_addr),
        .o_rd_en             (o_rd_en),
        .o_bias_result       (o_bias_result),
        .o_bias_result_valid (o_bias_result_valid),
        .o_relu_data         (o_relu_data),
        .o_avg_result        (o_avg_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_assert = 0;
    int              n_fail   = 0;
    logic [L*AW-1:0] exp_q[$];
    logic [L*AW-1:0] bias_exp;
    logic            model_run;

    task automatic check(input string tag, input logic [L*AW-1:0] obs, input logic [L*AW-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [L*AW-1:0] model_bias(input logic [L*AW-1:0] npe,
                                                   input logic [L*AW-1:0] b,
                                                   input logic            run);
        logic [L*AW-1:0] r;
        longint          s;
        if (!run) return npe;
        r = '0;
        for (int i = 0; i < L; i++) begin
            s = longint'($signed(npe[AW*i +: AW])) + longint'($signed(b[AW*i +: AW]));
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            else if (s < -64'sd2147483648) s = -64'sd2147483648;
            r[AW*i +: AW] = s[AW-1:0];
        end
        return r;
    endfunction

    function automatic logic [L*AW-1:0] model_avg(input logic [L*PW-1:0] m, input logic [7:0] c);
        logic [L*AW-1:0] r;
        int              p;
        r = '0;
        for (int i = 0; i < L; i++) begin
            p = int'($signed(m[PW*i +: PW])) * int'({24'd0, c});
            r[AW*i +: AW] = p;
        end
        return AVG_ON ? r : '0;
    endfunction

    function automatic logic [L*AW-1:0] rand_vec();
        logic [L*AW-1:0] v;
        for (int i = 0; i < L; i++) v[AW*i +: AW] = $urandom;
        return v;
    endfunction

    // One clock: predict, let the edge happen, then compare away from the edge.
    task automatic cycle();
        logic            nxt_run;
        logic [L*AW-1:0] e;
        if (npe_data_valid) exp_q.push_back(model_bias(npe_data, bias_exp, model_run));
        nxt_run = calculate_enable && !calculate_end;
        @(posedge clk);
        if (bias_data_valid) bias_exp = bias_data;
        model_run = nxt_run;
        #1;
        if (o_bias_result_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", o_bias_result_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_bias_result", o_bias_result, e);
            end
        end else begin
            check("bias_zero_when_invalid", o_bias_result, 0);
        end
    endtask

    logic [7:0]      addr_tab [6];
    logic [L*AW-1:0] v;
    logic [L*PW-1:0] m;

    initial begin
        addr_tab = '{8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h10};
        bias_exp  = '0;
        model_run = 1'b0;

        // Reset with every input active: nothing may leak out.
        rst              = 1'b0;
        calculate_enable = 1'b1;
        calculate_end    = 1'b0;
        part_num         = 5'd3;
        out_piece        = 8'd3;
        addr_start_b     = 8'h55;
        npe_data         = rand_vec();
        npe_data_valid   = 1'b1;
        pe_out_en        = 1'b1;
        bias_data        = rand_vec();
        bias_data_valid  = 1'b1;
        relu_en          = 1'b0;
        avg_coe          = 8'd9;
        for (int i = 0; i < L; i++) avg_mdata[PW*i +: PW] = 16'($urandom_range(1, 1000));
        repeat (3) @(posedge clk);
        #1;
        check("rst_b_addr", o_b_addr, 0);
        check("rst_rd_en", o_rd_en, 0);
        check("rst_bias_result", o_bias_result, 0);
        check("rst_bias_valid", o_bias_result_valid, 0);
        check("rst_avg_result", o_avg_result, 0);
        check("rst_relu_data", o_relu_data, 0);

        // Release: first cycle is IDLE, so data passes through and rd_en stays low.
        bias_data_valid = 1'b0;
        addr_start_b    = 8'h10;
        v               = rand_vec();
        npe_data        = v;
        rst             = 1'b1;
        cycle();
        check("release_passthrough", o_bias_result, v);
        check("release_rd_en", o_rd_en, 0);
        check("enter_run_addr", o_b_addr, 8'h10);

        // Load bias (lane0 = -30) with pe_out_en high in RUN.
        npe_data_valid  = 1'b0;
        bias_data       = rand_vec();
        bias_data[31:0] = -32'sd30;
        bias_data_valid = 1'b1;
        cycle();
        check("rd_en_follows_pe_out_en", o_rd_en, 1);

        // Bias add: 100 + (-30) = 70, valid exactly one cycle later.
        bias_data_valid = 1'b0;
        pe_out_en       = 1'b0;
        npe_data        = rand_vec();
        npe_data[31:0]  = 32'd100;
        npe_data_valid  = 1'b1;
        cycle();
        check("bias_add_lane0", o_bias_result[31:0], 32'd70);
        check("bias_valid_after_1", o_bias_result_valid, 1);
        check("rd_en_drops", o_rd_en, 0);
        npe_data_valid = 1'b0;
        cycle();
        check("bias_valid_clears", o_bias_result_valid, 0);

        // Saturation at both ends plus random lanes.
        bias_data        = rand_vec();
        bias_data[31:0]  = 32'h0000_0100;
        bias_data[63:32] = 32'hFFFF_FF00;
        bias_data_valid  = 1'b1;
        cycle();
        bias_data_valid  = 1'b0;
        npe_data         = rand_vec();
        npe_data[31:0]   = 32'h7FFF_FFF0;
        npe_data[63:32]  = 32'h8000_0010;
        npe_data_valid   = 1'b1;
        cycle();
        check("sat_pos_lane0", o_bias_result[31:0], 32'h7FFF_FFFF);
        check("sat_neg_lane1", o_bias_result[63:32], 32'h8000_0000);

        // ReLU: lane0 = -261 + 256 = -5, lane1 = 300 - 256 = 44.
        npe_data        = rand_vec();
        npe_data[31:0]  = -32'sd261;
        npe_data[63:32] = 32'd300;
        relu_en         = 1'b1;
        cycle();
        check("relu_neg_lane0", o_relu_data[31:0], 32'd0);
        check("relu_pos_lane1", o_relu_data[63:32], 32'd44);
        relu_en = 1'b0;
        #1;
        check("relu_off_lane0", o_relu_data[31:0], 32'hFFFF_FFFB);
        check("relu_off_full", o_relu_data, o_bias_result);
        npe_data_valid = 1'b0;

        // Addressing: leave the layer, re-enter with 2 beats x 3 pieces.
        calculate_enable = 1'b0;
        cycle();
        part_num         = 5'd1;
        out_piece        = 8'd2;
        addr_start_b     = 8'h10;
        calculate_enable = 1'b1;
        cycle();
        check("addr_reload", o_b_addr, 8'h10);
        npe_data_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            npe_data = rand_vec();
            cycle();
            check($sformatf("addr_after_beat%0d", k + 1), o_b_addr, addr_tab[k]);
        end
        npe_data_valid = 1'b0;

        // Average pool, registered one cycle.
        for (int i = 0; i < L; i++) avg_mdata[PW*i +: PW] = 16'($urandom);
        avg_mdata[15:0] = -16'sd4;
        avg_coe         = 8'd9;
        m               = avg_mdata;
        cycle();
        check("avg_lane0", o_avg_result[31:0], AVG_ON ? 32'hFFFF_FFDC : 32'd0);
        check("avg_full_coe9", o_avg_result, model_avg(m, 8'd9));
        avg_mdata[15:0] = 16'h8000;
        avg_coe         = 8'd255;
        m               = avg_mdata;
        cycle();
        check("avg_full_coe255", o_avg_result, model_avg(m, 8'd255));

        // calculate_end on beat 1 drops to IDLE; next beat passes through.
        npe_data_valid = 1'b1;
        pe_out_en      = 1'b1;
        npe_data       = rand_vec();
        cycle();
        check("rd_en_before_end", o_rd_en, 1);
        npe_data      = rand_vec();
        calculate_end = 1'b1;
        cycle();
        check("rd_en_after_end", o_rd_en, 0);
        v        = rand_vec();
        npe_data = v;
        cycle();
        check("idle_passthrough", o_bias_result, v);
        check("idle_rd_en", o_rd_en, 0);

        npe_data_valid   = 1'b0;
        pe_out_en        = 1'b0;
        calculate_end    = 1'b0;
        calculate_enable = 1'b0;
        repeat (2) cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
